// File: rtl/mfp_ahb_rojo_multi.sv
// AHB-lite slave serving up to four RojoBot channels: control out, info/update in, sticky flags, one IRQ.
// Optional: MFP_ROJO_INFO_SNAPSHOT_EN latches IO_BotInfo on each update edge so INFO reads are coherent.
module mfp_ahb_rojo_multi #(
    parameter int NUM_BOTS = 2,
    parameter int CTRL_W   = 8,
    parameter int INFO_W   = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic [31:0]                  HWDATA,
    input  logic                         HWRITE,
    input  logic                         HSEL,
    output logic [31:0]                  HRDATA,
    output logic [NUM_BOTS*CTRL_W-1:0]   IO_BotCtrl,
    input  logic [NUM_BOTS*INFO_W-1:0]   IO_BotInfo,
    input  logic [NUM_BOTS-1:0]          IO_BotUpdt_Sync,
    output logic [NUM_BOTS-1:0]          IO_INT_ACK,
    output logic                         IRQ
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'hF0;
    localparam logic [7:0] ADDR_PEND_SUM = 8'hF4;

    logic [7:0]                        haddr_q, haddr_d;
    logic                              hwrite_q, hwrite_d;
    logic                              hsel_q, hsel_d;
    logic [1:0]                        htrans_q, htrans_d;
    logic [31:0]                       hrdata_q, hrdata_d;
    logic [NUM_BOTS-1:0][CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [NUM_BOTS-1:0]               pending_q, pending_d;
    logic [NUM_BOTS-1:0]               overrun_q, overrun_d;
    logic [NUM_BOTS-1:0]               irq_en_q, irq_en_d;
    logic [NUM_BOTS-1:0]               updt_prev_q, updt_prev_d;
    logic [NUM_BOTS-1:0]               int_ack_q, int_ack_d;

    logic [NUM_BOTS-1:0][INFO_W-1:0]   info_src;
    logic [NUM_BOTS-1:0]               updt_rise;
    logic [NUM_BOTS-1:0]               ack_pend;
    logic [NUM_BOTS-1:0]               ack_ovr;
    logic                              wr_en;
    logic                              rd_en;
    logic [31:0]                       rd_data;
    logic                              unused_bits;

    assign unused_bits = ^{HADDR[31:8], HWDATA};

`ifdef MFP_ROJO_INFO_SNAPSHOT_EN
    logic [NUM_BOTS-1:0][INFO_W-1:0]   snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        for (int n = 0; n < NUM_BOTS; n++) begin
            if (updt_rise[n]) snap_d[n] = IO_BotInfo[n*INFO_W +: INFO_W];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) snap_q <= '0;
        else          snap_q <= snap_d;
    end

    assign info_src = snap_q;
`else
    assign info_src = IO_BotInfo;
`endif

    assign wr_en     = hsel_q && hwrite_q && (htrans_q != HTRANS_IDLE);
    assign rd_en     = HSEL && !HWRITE && (HTRANS != HTRANS_IDLE);
    assign updt_rise = IO_BotUpdt_Sync & ~updt_prev_q;

    // Read mux decodes the live address-phase HADDR; result is registered into HRDATA.
    always_comb begin
        rd_data = '0;
        if (HADDR[1:0] == 2'b00) begin
            for (int n = 0; n < NUM_BOTS; n++) begin
                if (HADDR[7:4] == 4'(n)) begin
                    case (HADDR[3:2])
                        2'd0:    rd_data[INFO_W-1:0] = info_src[n];
                        2'd1:    rd_data[CTRL_W-1:0] = ctrl_q[n];
                        2'd2:    rd_data[1:0]        = {overrun_q[n], pending_q[n]};
                        default: rd_data             = '0;
                    endcase
                end
            end
            if (HADDR[7:0] == ADDR_IRQ_EN)   rd_data[NUM_BOTS-1:0] = irq_en_q;
            if (HADDR[7:0] == ADDR_PEND_SUM) rd_data[NUM_BOTS-1:0] = pending_q;
        end
    end

    always_comb begin
        haddr_d     = HADDR[7:0];
        hwrite_d    = HWRITE;
        hsel_d      = HSEL;
        htrans_d    = HTRANS;
        hrdata_d    = rd_en ? rd_data : hrdata_q;
        ctrl_d      = ctrl_q;
        irq_en_d    = irq_en_q;
        ack_pend    = '0;
        ack_ovr     = '0;
        updt_prev_d = IO_BotUpdt_Sync;

        if (wr_en && (haddr_q[1:0] == 2'b00)) begin
            for (int n = 0; n < NUM_BOTS; n++) begin
                if (haddr_q[7:4] == 4'(n)) begin
                    case (haddr_q[3:2])
                        2'd1: ctrl_d[n] = HWDATA[CTRL_W-1:0];
                        2'd3: begin
                            ack_pend[n] = HWDATA[0];
                            ack_ovr[n]  = HWDATA[1];
                        end
                        default: ;
                    endcase
                end
            end
            if (haddr_q == ADDR_IRQ_EN) irq_en_d = HWDATA[NUM_BOTS-1:0];
        end

        // A new edge beats a same-cycle clear; overrun only counts against pending that survives the clear.
        pending_d = (pending_q & ~ack_pend) | updt_rise;
        overrun_d = (overrun_q & ~ack_ovr) | (updt_rise & pending_q & ~ack_pend);
        int_ack_d = ack_pend;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hrdata_q    <= '0;
            ctrl_q      <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
            irq_en_q    <= '0;
            updt_prev_q <= '0;
            int_ack_q   <= '0;
        end else begin
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            hrdata_q    <= hrdata_d;
            ctrl_q      <= ctrl_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            irq_en_q    <= irq_en_d;
            updt_prev_q <= updt_prev_d;
            int_ack_q   <= int_ack_d;
        end
    end

    assign HRDATA     = hrdata_q;
    assign IO_BotCtrl = ctrl_q;
    assign IO_INT_ACK = int_ack_q;
    assign IRQ        = |(pending_q & irq_en_q);

endmodule

// File: tb/tb_mfp_ahb_rojo_multi.sv
// Self-checking bench for mfp_ahb_rojo_multi (NUM_BOTS=2, CTRL_W=8, INFO_W=32) against a register-level model.
module tb_mfp_ahb_rojo_multi;

    localparam int NB = 2;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic [15:0] IO_BotCtrl;
    logic [63:0] IO_BotInfo;
    logic [1:0]  IO_BotUpdt_Sync;
    logic [1:0]  IO_INT_ACK;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_ctrl [NB];
    logic        m_pend [NB];
    logic        m_ovr  [NB];
    logic [31:0] m_snap [NB];
    logic [1:0]  m_irqen;

    mfp_ahb_rojo_multi #(.NUM_BOTS(2), .CTRL_W(8), .INFO_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA),
        .IO_BotCtrl(IO_BotCtrl), .IO_BotInfo(IO_BotInfo),
        .IO_BotUpdt_Sync(IO_BotUpdt_Sync), .IO_INT_ACK(IO_INT_ACK), .IRQ(IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_ctrl[i] = '0; m_pend[i] = 1'b0; m_ovr[i] = 1'b0; m_snap[i] = '0;
        end
        m_irqen = '0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int ch;
        ch = int'(a[7:4]);
        if (a == 8'hF0) return {30'b0, m_irqen};
        if (a == 8'hF4) return {30'b0, m_pend[1], m_pend[0]};
        if (ch < NB) begin
            case (a[3:0])
`ifdef MFP_ROJO_INFO_SNAPSHOT_EN
                4'h0: return m_snap[ch];
`else
                4'h0: return IO_BotInfo[ch*32 +: 32];
`endif
                4'h4: return {24'b0, m_ctrl[ch]};
                4'h8: return {30'b0, m_ovr[ch], m_pend[ch]};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    // Returns the IO_INT_ACK pattern a qualified write should produce.
    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d);
        logic [1:0] ack;
        int ch;
        ack = '0;
        ch  = int'(a[7:4]);
        if (a == 8'hF0) m_irqen = d[1:0];
        else if (ch < NB) begin
            if (a[3:0] == 4'h4) m_ctrl[ch] = d[7:0];
            if (a[3:0] == 4'hC) begin
                if (d[0]) begin m_pend[ch] = 1'b0; ack[ch] = 1'b1; end
                if (d[1]) m_ovr[ch] = 1'b0;
            end
        end
        return ack;
    endfunction

    function automatic void model_edge(input int ch);
        if (m_pend[ch]) m_ovr[ch] = 1'b1;
        m_pend[ch] = 1'b1;
        m_snap[ch] = IO_BotInfo[ch*32 +: 32];
    endfunction

    function automatic logic exp_irq();
        return (m_pend[0] & m_irqen[0]) | (m_pend[1] & m_irqen[1]);
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] tr);
        @(negedge HCLK);
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = tr; HADDR = {24'h0, a};
        @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HWRITE = 1'b0; HTRANS = 2'b10; HADDR = {24'h0, a};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic pulse_updt(input int ch);
        @(negedge HCLK);
        IO_BotUpdt_Sync[ch] = 1'b1;
        @(negedge HCLK);
        IO_BotUpdt_Sync[ch] = 1'b0;
        model_edge(ch);
    endtask

    task automatic check_read(input logic [7:0] a, input string name);
        logic [31:0] got, exp;
        bus_read(a, got);
        exp = exp_read(a);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s addr=%02h got=%08h exp=%08h", name, a, got, exp);
        end
    endtask

    task automatic check_write(input logic [7:0] a, input logic [31:0] d, input string name);
        logic [1:0] exp_ack;
        exp_ack = model_write(a, d);
        bus_write(a, d, 2'b10);
        checks++;
        if (IO_INT_ACK !== exp_ack) begin
            errors++;
            $display("FAIL %s int_ack addr=%02h got=%b exp=%b", name, a, IO_INT_ACK, exp_ack);
        end
        @(negedge HCLK);
        checks++;
        if (IO_INT_ACK !== 2'b00) begin
            errors++;
            $display("FAIL %s int_ack_width got=%b exp=00", name, IO_INT_ACK);
        end
    endtask

    task automatic check_outputs(input string name);
        checks++;
        if (IO_BotCtrl !== {m_ctrl[1], m_ctrl[0]}) begin
            errors++;
            $display("FAIL %s bot_ctrl got=%04h exp=%04h", name, IO_BotCtrl, {m_ctrl[1], m_ctrl[0]});
        end
        checks++;
        if (IRQ !== exp_irq()) begin
            errors++;
            $display("FAIL %s irq got=%b exp=%b", name, IRQ, exp_irq());
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00;
        HADDR = '0; HWDATA = '0; IO_BotInfo = '0; IO_BotUpdt_Sync = '0;
        model_reset();
        repeat (3) @(negedge HCLK);
        checks++;
        if (HRDATA !== 32'h0 || IO_INT_ACK !== 2'b00) begin
            errors++;
            $display("FAIL reset_outs got hrdata=%08h ack=%b exp 0", HRDATA, IO_INT_ACK);
        end
        check_outputs("reset");
        HRESETn = 1'b1;
        for (int a = 0; a < 256; a += 4) check_read(8'(a), "reset_read");
    endtask

    task automatic test_ctrl();
        check_write(8'h04, 32'h0000_00A5, "ctrl0");
        check_write(8'h14, 32'h0000_003C, "ctrl1");
        checks++;
        if (IO_BotCtrl !== 16'h3CA5) begin
            errors++;
            $display("FAIL ctrl_pack got=%04h exp=3ca5", IO_BotCtrl);
        end
        check_read(8'h04, "ctrl0_rb");
        check_read(8'h14, "ctrl1_rb");
    endtask

    task automatic test_unqualified();
        bus_write(8'h04, 32'h0000_0011, 2'b00);
        check_outputs("idle_write");
        check_write(8'h24, 32'hFFFF_FFFF, "unmapped_write");
        check_read(8'h24, "unmapped_read");
        check_outputs("unmapped");
    endtask

    task automatic test_irq_ack();
        check_write(8'hF0, 32'h2, "irq_en");
        pulse_updt(1);
        check_read(8'h18, "status1");
        check_read(8'hF4, "pend_sum");
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got=%b exp=1", IRQ);
        end
        check_write(8'h1C, 32'h1, "ack1");
        check_read(8'h18, "status1_clr");
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr got=%b exp=0", IRQ);
        end
        check_read(8'h0C, "ack_reg_read");
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        pulse_updt(0);
        pulse_updt(0);
        check_read(8'h08, "status0_ovr");
        // Update edge lands on the same clock as the ACK data phase.
        @(negedge HCLK);
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = 32'h0C;
        @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = 32'h3;
        IO_BotUpdt_Sync[0] = 1'b1;
        @(negedge HCLK);
        IO_BotUpdt_Sync[0] = 1'b0;
        m_pend[0] = 1'b1; m_ovr[0] = 1'b0; m_snap[0] = IO_BotInfo[31:0];
        bus_read(8'h08, got);
        checks++;
        if (got !== 32'h1) begin
            errors++;
            $display("FAIL edge_vs_ack got=%08h exp=00000001", got);
        end
    endtask

    task automatic test_info();
        check_write(8'h0C, 32'h3, "info_pre_ack");
        IO_BotInfo[31:0] = 32'h1234_5678;
        pulse_updt(0);
        IO_BotInfo[31:0] = 32'hDEAD_BEEF;
        check_read(8'h00, "info_read");
    endtask

    task automatic test_reset_midtransfer();
        @(negedge HCLK);
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = 32'h04;
        @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFF;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_reset();
        check_outputs("midreset");
        check_read(8'h04, "midreset_ctrl");
    endtask

    task automatic test_random();
        int op, ch;
        logic [7:0] a;
        for (int it = 0; it < 200; it++) begin
            op = int'($urandom_range(0, 5));
            a  = 8'($urandom_range(0, 63) * 4);
            ch = int'($urandom_range(0, NB - 1));
            case (op)
                0: check_read(a, "rnd_read");
                1: check_write(a, $urandom, "rnd_write");
                2: pulse_updt(ch);
                3: check_write(8'(ch * 16 + 12), 32'($urandom_range(0, 3)), "rnd_ack");
                4: check_write(8'hF0, $urandom, "rnd_irqen");
                default: IO_BotInfo = {$urandom, $urandom};
            endcase
            @(negedge HCLK);
            check_outputs("rnd");
        end
        for (int a2 = 0; a2 < 256; a2 += 4) check_read(8'(a2), "rnd_sweep");
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_unqualified();
        test_irq_ack();
        test_overrun();
        test_info();
        test_reset_midtransfer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mfp_ahb_rojo_multi.md
Name: mfp_ahb_rojo_multi

Overview:
AHB-lite slave peripheral serving up to four RojoBot channels from one bus slot.
- Per channel: control register out, bot info and update status in.
- Sticky update-pending and overrun flags per channel, with software acknowledge.
- One combined, maskable interrupt request line.
- Sits on the MFP AHB-lite bus beside the other mfp_ahb_* peripherals; selected by HSEL from the bus decoder.

Parameters:
- NUM_BOTS, 2, number of bot channels (1..4).
- CTRL_W, 8, width of each bot control register (1..32).
- INFO_W, 32, width of each bot info word (1..32); zero-extended on read.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  address; only HADDR[7:0] is decoded.
- HTRANS  in  2  transfer type.
- HWDATA  in  32  write data (data phase).
- HWRITE  in  1  write strobe (address phase).
- HSEL  in  1  slave select.
- HRDATA  out  32  read data.
- IO_BotCtrl  out  NUM_BOTS*CTRL_W  control word; channel n occupies [n*CTRL_W +: CTRL_W].
- IO_BotInfo  in  NUM_BOTS*INFO_W  bot info words, same packing.
- IO_BotUpdt_Sync  in  NUM_BOTS  per-bot update level, already synchronous to HCLK.
- IO_INT_ACK  out  NUM_BOTS  one-cycle acknowledge pulse per channel.
- IRQ  out  1  OR of (pending & irq_en) over all channels.

Behaviour:
- Register map, byte offsets, word access only. Channel n base is n*0x10.
  - +0x0 INFO: RO.
  - +0x4 CTRL: RW, CTRL_W bits.
  - +0x8 STATUS: RO; bit0 pending, bit1 overrun.
  - +0xC ACK: WO, write-1-to-clear; bit0 clears pending, bit1 clears overrun.
  - 0xF0 IRQ_EN: RW, NUM_BOTS bits.
  - 0xF4 PEND_SUM: RO, bit n = pending[n].
- Channel index >= NUM_BOTS, or any other offset: reads return 0, writes ignored.
- Write pipeline:
  - HADDR, HWRITE, HSEL, HTRANS registered on every HCLK edge.
  - Write enable = delayed HSEL & delayed HWRITE & (delayed HTRANS != IDLE).
  - Register updates from HWDATA on the clock edge ending the data phase.
  - No write without a qualified address phase.
- Read pipeline:
  - HRDATA is registered from the address-phase HADDR when HSEL & !HWRITE & HTRANS != IDLE; otherwise it holds its value.
  - Data is valid in the data phase; zero wait states; no HREADY/HRESP outputs.
- Update detection:
  - Per channel, a rising edge of IO_BotUpdt_Sync (registered previous value vs current) sets pending.
  - An edge while pending is already 1 sets overrun.
  - An edge and an ACK clear of the same bit in the same cycle: set wins; flag ends at 1.
- IO_INT_ACK[n]:
  - 1 for exactly one cycle after each qualified ACK write to channel n with bit0 = 1.
  - Never asserted by reads or by writes to other offsets.
- IRQ is combinational from registered pending and irq_en; glitch-free because both are flops.
- Reset values, asynchronous on HRESETn low: IO_BotCtrl 0, IO_INT_ACK 0, HRDATA 0, pending 0, overrun 0, irq_en 0, edge-detect register 0, pipeline registers 0. IRQ is therefore 0.
- Reset asserted mid-transfer aborts the transfer; no partial register write.
- First cycle after reset: an IO_BotUpdt_Sync that is already high registers as an edge.

Optional Feature:
- Macro: MFP_ROJO_INFO_SNAPSHOT_EN.
- Defined: each channel holds an INFO_W snapshot register, loaded from IO_BotInfo on the same edge that sets pending. INFO reads return the snapshot, so the value is coherent with the update being serviced. Snapshot resets to 0.
- Undefined: INFO reads return live IO_BotInfo sampled in the read's address phase. No snapshot flops are generated.

Test Plan:
- Reset, then read all offsets -> all 0, IRQ 0, IO_BotCtrl 0.
- Write 0xA5 to 0x04, then 0x3C to 0x14 -> IO_BotCtrl = 0x3CA5 (NUM_BOTS 2, CTRL_W 8); read-back returns 0xA5 and 0x3C.
- Write with HTRANS = IDLE, HSEL = 1, HWRITE = 1 to 0x04 -> IO_BotCtrl unchanged; write to unmapped 0x24 -> ignored, reads 0.
- Pulse IO_BotUpdt_Sync[1], IRQ_EN = 0x2 -> STATUS at 0x18 = 0x1, PEND_SUM = 0x2, IRQ = 1. Write 0x1 to 0x1C -> IO_INT_ACK[1] high one cycle, pending 0, IRQ 0.
- Two edges on channel 0 without ACK -> STATUS = 0x3. Edge coinciding with an ACK write of 0x3 -> STATUS ends at 0x1.
- With MFP_ROJO_INFO_SNAPSHOT_EN defined: IO_BotInfo[0] = 0x12345678 at the edge, then changed to 0xDEADBEEF -> read 0x00 returns 0x12345678. Without the macro, the same read returns 0xDEADBEEF.
